uart_rx_core: RTL



---
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with fixed clocks-per-bit timing and single-cycle byte/error strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit (8E1) and expose parity_err.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_BITS     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [CNT_BITS-1:0] HALF_CMP = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] FULL_CMP = CNT_BITS'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [7:0]          shift_reg, shift_next;
  logic [7:0]          data_reg, data_next;
  logic                valid_reg, valid_next;
  logic                frame_err_reg, frame_err_next;
  logic [1:0]          rx_sync_reg;
  logic                rx_s;
`ifdef UART_RX_PARITY_EN
  logic                parity_bit_reg, parity_bit_next;
  logic                parity_err_reg, parity_err_next;
`endif

  // Synchronizer idles high so reset never looks like a start edge.
  assign rx_s = rx_sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_reg    <= 2'b11;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      rx_sync_reg    <= {rx_sync_reg[0], rx};
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (cnt_reg == HALF_CMP) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == FULL_CMP) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == FULL_CMP) begin
          cnt_next        = '0;
          parity_bit_next = rx_s;
          state_next      = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt_reg == FULL_CMP) begin
          cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_next = (^shift_reg) ^ parity_bit_reg;
`endif
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // A held-low line (break) must not be re-parsed as a stream of start bits.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign data       = data_reg;
  assign valid      = valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule
